// File: rtl/display_pkg.sv
// Shared types and constants for the scrolling seven-segment display.
// Segment patterns are active-low with bit order {g,f,e,d,c,b,a}.
package display_pkg;

    typedef logic [2:0] digit_idx_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Index 0 is the rightmost entry; listed F down to 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [7:0] an_select(input digit_idx_t idx);
        an_select = ~(8'b0000_0001 << idx);
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex-to-seven-segment decoder, active-low outputs.
module hex7seg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup covers all sixteen hex values.
    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/scroll_display.sv
// Scrolling eight-digit hex message display: a nibble-rotating message
// register feeding a time-multiplexed, glitch-free seven-segment scanner.
module scroll_display
    import display_pkg::*;
#(
    parameter int SCROLL_DIV = 50_000_000,
    parameter int SCAN_DIV   = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic        shift_en,
    input  logic        disp_src,
    input  logic [31:0] mem_data,
    input  logic [31:0] sw_data,
    output logic [6:0]  seg,
    output logic [7:0]  an,
    output logic        dp
);

    localparam int SCROLL_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCROLL_W-1:0] SCROLL_LAST = SCROLL_W'(SCROLL_DIV - 1);
    localparam logic [SCAN_W-1:0]   SCAN_LAST   = SCAN_W'(SCAN_DIV - 1);

    logic [31:0]         msg_r;
    logic [SCROLL_W-1:0] scroll_cnt_r;
    logic [31:0]         disp_word_r;
    logic                src_r;
    logic [SCAN_W-1:0]   scan_cnt_r;
    digit_idx_t          idx_r;

    logic                scan_wrap_s;
    logic [3:0]          nibble_s;
    logic [6:0]          seg_dec_s;

    // idx_r names the digit to light at the next scan step, so digit 0
    // comes up first after reset.
    always_comb begin
        scan_wrap_s = (scan_cnt_r == SCAN_LAST);
        nibble_s    = disp_word_r[{idx_r, 2'b00} +: 4];
    end

    hex7seg u_hex7seg (
        .nibble (nibble_s),
        .seg    (seg_dec_s)
    );

    // Message register: load wins over timed rotation; idle clears the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_r        <= 32'h0000_0000;
            scroll_cnt_r <= '0;
        end else if (load_en) begin
            msg_r        <= mem_data;
            scroll_cnt_r <= '0;
        end else if (shift_en) begin
            if (scroll_cnt_r == SCROLL_LAST) begin
                msg_r        <= {msg_r[27:0], msg_r[31:28]};
                scroll_cnt_r <= '0;
            end else begin
                msg_r        <= msg_r;
                scroll_cnt_r <= scroll_cnt_r + SCROLL_W'(1);
            end
        end else begin
            msg_r        <= msg_r;
            scroll_cnt_r <= '0;
        end
    end

    // Display word and its source flag are captured together each cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_word_r <= 32'h0000_0000;
            src_r       <= 1'b0;
        end else begin
            disp_word_r <= disp_src ? sw_data : msg_r;
            src_r       <= disp_src;
        end
    end

    // Free-running scan prescaler and digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_r <= '0;
            idx_r      <= 3'd0;
        end else if (scan_wrap_s) begin
            scan_cnt_r <= '0;
            idx_r      <= idx_r + 3'd1;
        end else begin
            scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
            idx_r      <= idx_r;
        end
    end

    // Anode, segments and decimal point switch on the same edge: no ghosting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else if (scan_wrap_s) begin
            an  <= an_select(idx_r);
            seg <= seg_dec_s;
            dp  <= ~((idx_r == 3'd0) && src_r);
        end else begin
            an  <= an;
            seg <= seg;
            dp  <= dp;
        end
    end

endmodule

// File: tb/tb_scroll_display.sv
// Directed self-checking bench for scroll_display with short dividers.
module tb_scroll_display;

    logic        clk;
    logic        rst;
    logic        load_en;
    logic        shift_en;
    logic        disp_src;
    logic [31:0] mem_data;
    logic [31:0] sw_data;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic        dp;

    int tests;
    int fails;

    scroll_display #(
        .SCROLL_DIV (4),
        .SCAN_DIV   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load_en  (load_en),
        .shift_en (shift_en),
        .disp_src (disp_src),
        .mem_data (mem_data),
        .sw_data  (sw_data),
        .seg      (seg),
        .an       (an),
        .dp       (dp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    logic [6:0] seg_cap [8];
    logic [7:0] an_exp  [8];
    logic       found;

    initial begin
        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        load_en  = 1'b0;
        shift_en = 1'b0;
        disp_src = 1'b0;
        mem_data = 32'h0000_0000;
        sw_data  = 32'h0000_0000;
        for (int d = 0; d < 8; d++) seg_cap[d] = 7'h7F;
        an_exp[0] = 8'hFD; an_exp[1] = 8'hFB; an_exp[2] = 8'hF7; an_exp[3] = 8'hEF;
        an_exp[4] = 8'hDF; an_exp[5] = 8'hBF; an_exp[6] = 8'h7F; an_exp[7] = 8'hFE;

        // Reset values.
        #12;
        chk("rst_an", {24'h0, an}, 32'h0000_00FF);
        chk("rst_seg", {25'h0, seg}, 32'h0000_007F);
        chk("rst_dp", {31'h0, dp}, 32'h0000_0001);
        chk("rst_msg", dut.msg_r, 32'h0000_0000);
        tick();
        rst = 1'b0;

        // Load DEADBEEF.
        load_en  = 1'b1;
        mem_data = 32'hDEAD_BEEF;
        tick();
        load_en = 1'b0;
        chk("load_msg", dut.msg_r, 32'hDEAD_BEEF);

        // Capture each digit's segments during scanning.
        for (int c = 0; c < 40; c++) begin
            tick();
            for (int d = 0; d < 8; d++) begin
                if (an == ~(8'b0000_0001 << d)) seg_cap[d] = seg;
            end
        end
        chk("dig0_F", {25'h0, seg_cap[0]}, 32'h0000_000E);
        chk("dig1_E", {25'h0, seg_cap[1]}, 32'h0000_0006);
        chk("dig3_b", {25'h0, seg_cap[3]}, 32'h0000_0003);
        chk("dig4_D", {25'h0, seg_cap[4]}, 32'h0000_0021);
        chk("dig5_A", {25'h0, seg_cap[5]}, 32'h0000_0008);
        chk("dig7_d", {25'h0, seg_cap[7]}, 32'h0000_0021);

        // Timed scrolling.
        shift_en = 1'b1;
        tick(); tick(); tick();
        chk("scroll_3", dut.msg_r, 32'hDEAD_BEEF);
        tick();
        chk("scroll_4", dut.msg_r, 32'hEADB_EEFD);
        for (int c = 0; c < 4; c++) tick();
        chk("scroll_8", dut.msg_r, 32'hADBE_EFDE);
        for (int c = 0; c < 24; c++) tick();
        chk("scroll_32", dut.msg_r, 32'hDEAD_BEEF);
        shift_en = 1'b0;
        tick();

        // Load has priority over shift.
        shift_en = 1'b1;
        load_en  = 1'b1;
        mem_data = 32'h1234_5678;
        tick();
        chk("prio_load", dut.msg_r, 32'h1234_5678);
        load_en = 1'b0;
        tick(); tick(); tick();
        chk("prio_hold3", dut.msg_r, 32'h1234_5678);
        tick();
        chk("prio_rot4", dut.msg_r, 32'h2345_6781);
        shift_en = 1'b0;
        tick();

        // Programming view.
        disp_src = 1'b1;
        sw_data  = 32'h0000_000F;
        for (int c = 0; c < 18; c++) tick();
        for (int c = 0; c < 16; c++) begin
            chk("sw_onehot", $countones(~an), 32'd1);
            if (an == 8'hFE) begin
                chk("sw_d0_seg", {25'h0, seg}, 32'h0000_000E);
                chk("sw_d0_dp", {31'h0, dp}, 32'h0000_0000);
            end else begin
                chk("sw_dn_seg", {25'h0, seg}, 32'h0000_0040);
                chk("sw_dn_dp", {31'h0, dp}, 32'h0000_0001);
            end
            tick();
        end

        // Anode scan order and hold between steps.
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (an != 8'hFE) found = 1'b1;
        end
        chk("wait_leave_fe", {31'h0, found}, 32'h0000_0001);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (an == 8'hFE) found = 1'b1;
        end
        chk("wait_fe", {31'h0, found}, 32'h0000_0001);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("scan_hold", {24'h0, an}, (k == 0) ? 32'h0000_00FE : {24'h0, an_exp[k-1]});
            tick();
            chk("scan_step", {24'h0, an}, {24'h0, an_exp[k]});
        end
        disp_src = 1'b0;

        // Reset in the middle of a scroll period.
        shift_en = 1'b1;
        tick(); tick();
        chk("mid_cnt2", {30'h0, dut.scroll_cnt_r}, 32'd2);
        rst = 1'b1;
        #1;
        chk("mid_rst_an", {24'h0, an}, 32'h0000_00FF);
        chk("mid_rst_seg", {25'h0, seg}, 32'h0000_007F);
        chk("mid_rst_dp", {31'h0, dp}, 32'h0000_0001);
        chk("mid_rst_cnt", {30'h0, dut.scroll_cnt_r}, 32'd0);
        #1;
        rst = 1'b0;
        tick();
        chk("post_an_off", {24'h0, an}, 32'h0000_00FF);
        chk("post_cnt1", {30'h0, dut.scroll_cnt_r}, 32'd1);
        tick();
        chk("post_an_d0", {24'h0, an}, 32'h0000_00FE);
        tick();
        chk("post_cnt3", {30'h0, dut.scroll_cnt_r}, 32'd3);
        tick();
        chk("post_wrap", {30'h0, dut.scroll_cnt_r}, 32'd0);
        shift_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
